// File: rtl/uart_rx_if.sv
// Serial receive link: the Rx line in, received byte and status out.
// The receiver binds to the slave modport; whoever drives the line binds to master.
interface uart_rx_if;
  logic       Rx;
  logic [7:0] Data_received;
  logic       Rx_Done;
  logic       Parity_Error;
  logic       Rx_Busy;

  modport master (
    output Rx,
    input  Data_received, Rx_Done, Parity_Error, Rx_Busy
  );

  modport slave (
    input  Rx,
    output Data_received, Rx_Done, Parity_Error, Rx_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB-first, even parity, no stop bit.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote over the last three synchronized samples.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic     clock,
  input  logic     reset_n,
  uart_rx_if.slave rx_if
);

  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;

  state_t      state_q, state_d;
  logic        sync1, sync2, prev, fall_q, line;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic [7:0]  data_q;
  logic        perr_q, done_q;
  logic        cnt_zero, ld_half, ld_bit, take_bit, finish, busy;

  // Falling edge is registered once more so START is entered on the third edge
  // after the low level reaches sync1, which fixes every later sample point.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1  <= rx_if.Rx;
      sync2  <= sync1;
      prev   <= sync2;
      fall_q <= prev & ~sync2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic prev2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev2 <= 1'b0;
    else          prev2 <= prev;
  end

  assign line = maj3(sync2, prev, prev2);
`else
  assign line = sync2;
`endif

  assign cnt_zero = (cnt == 16'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall_q)                    state_d = START;
      START:  if (cnt_zero)                  state_d = line ? IDLE : DATA;
      DATA:   if (cnt_zero && idx == 3'd7)   state_d = PARITY;
      PARITY: if (cnt_zero)                  state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_half  = 1'b0;
    ld_bit   = 1'b0;
    take_bit = 1'b0;
    finish   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE:   ld_half  = fall_q;
      START:  ld_bit   = cnt_zero & ~line;
      DATA:   take_bit = cnt_zero;
      PARITY: finish   = cnt_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 16'd0;
      idx    <= 3'd0;
      data_q <= 8'h00;
      perr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (ld_half)
        cnt <= HALF_M1;
      else if (state_q != IDLE)
        cnt <= cnt_zero ? BIT_LAST : cnt - 16'd1;
      if (ld_bit)
        idx <= 3'd0;
      else if (take_bit)
        idx <= idx + 3'd1;
      if (finish) begin
        data_q <= shift;
        perr_q <= line ^ (^shift);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (take_bit) shift[idx] <= line;
  end

  assign rx_if.Data_received = data_q;
  assign rx_if.Parity_Error  = perr_q;
  assign rx_if.Rx_Done       = done_q;
  assign rx_if.Rx_Busy       = busy;

endmodule
